// File: rtl/serial_frame_deser_pkg.sv
// Shared types and line levels for the serial frame deserializer.
// Ports: none (package).
package serial_frame_deser_pkg;

    // Encoding 3 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_STOP = 2'd2
    } state_e;

    localparam logic START_LVL = 1'b1;
    localparam logic STOP_LVL  = 1'b0;
    localparam logic IDLE_LVL  = 1'b0;

endpackage

// File: rtl/serial_frame_deser_if.sv
// Bundle between the serial line/consumer side and the deserializer.
// master: drives din, bit_en, out_ready, clr_err; slave: drives the rest.
interface serial_frame_deser_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              din;
    logic              bit_en;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              frame_err;
    logic              overrun;
    logic              clr_err;
    logic [CNT_W-1:0]  frames_ok;
    logic [CNT_W-1:0]  overrun_cnt;

    modport master (
        output din, bit_en, out_ready, clr_err,
        input  out_data, out_valid, frame_err, overrun,
        input  frames_ok, overrun_cnt
    );

    modport slave (
        input  din, bit_en, out_ready, clr_err,
        output out_data, out_valid, frame_err, overrun,
        output frames_ok, overrun_cnt
    );
endinterface

// File: rtl/serial_frame_deser_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
// Ports: clk, rst (sync, active high), inc (count enable), count (value).
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/serial_frame_deser.sv
// Frames a strobed serial line (start 1, DATA_W bits LSB first, stop 0)
// into words on a one-entry valid/ready buffer, with sticky errors and stats.
// Ports: clk, rst (sync, active high), bus (slave side of the bundle).
module serial_frame_deser
    import serial_frame_deser_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input logic           clk,
    input logic           rst,
    serial_frame_deser_if.slave bus
);
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              ovr_q, ovr_d;

    logic good_stop;
    logic bad_stop;
    logic drain;
    logic load;
    logic drop;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        good_stop = 1'b0;
        bad_stop  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.bit_en && bus.din == START_LVL) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end
            end
            ST_DATA: begin
                if (bus.bit_en) begin
                    shreg_d[cnt_q] = bus.din;
                    cnt_d          = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d = ST_STOP;
                        cnt_d   = '0;
                    end
                end
            end
            ST_STOP: begin
                if (bus.bit_en) begin
                    // A bad stop bit is never re-read as a start bit.
                    state_d = ST_IDLE;
                    if (bus.din == STOP_LVL) begin
                        good_stop = 1'b1;
                    end else begin
                        bad_stop = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The buffer is free if empty or being drained on this same edge.
    always_comb begin
        drain   = valid_q && bus.out_ready;
        load    = good_stop && (!valid_q || bus.out_ready);
        drop    = good_stop && !load;
        data_d  = load ? shreg_q : data_q;
        valid_d = load || (valid_q && !drain);
        // Set events win over a simultaneous clear.
        ferr_d  = bad_stop || (ferr_q && !bus.clr_err);
        ovr_d   = drop || (ovr_q && !bus.clr_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_ok_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (load),
        .count (bus.frames_ok)
    );

    sat_counter #(.W(CNT_W)) u_ovr_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (drop),
        .count (bus.overrun_cnt)
    );

    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_serial_frame_deser.sv
// Directed and random frames through a d_ff stage into serial_frame_deser,
// checked against a frame-level model of buffer, flags and counters.
module tb_serial_frame_deser;
    localparam int DW   = 8;
    localparam int CWID = 2;
    localparam int CMAX = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_frame_deser_if #(.DATA_W(DW), .CNT_W(CWID)) bus ();

    serial_frame_deser #(.DATA_W(DW), .CNT_W(CWID)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // d_ff feeding the line; strobe and sideband share its cadence.
    logic d_drv, ben_drv, rdy_drv, clr_drv;
    logic dff_q, ben_q, rdy_q, clr_q;
    always_ff @(posedge clk) begin
        dff_q <= d_drv;
        ben_q <= ben_drv;
        rdy_q <= rdy_drv;
        clr_q <= clr_drv;
    end
    assign bus.din       = dff_q;
    assign bus.bit_en    = ben_q;
    assign bus.out_ready = rdy_q;
    assign bus.clr_err   = clr_q;

    int n_assert = 0;
    int n_fail   = 0;

    bit       m_valid;
    bit [7:0] m_data;
    bit       m_fe;
    bit       m_ov;
    int       m_ok;
    int       m_ovc;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'(m_valid));
        chk({tag, ".data"}, 32'(bus.out_data), 32'(m_data));
        chk({tag, ".ferr"}, 32'(bus.frame_err), 32'(m_fe));
        chk({tag, ".ovr"}, 32'(bus.overrun), 32'(m_ov));
        chk({tag, ".ok"}, 32'(bus.frames_ok), 32'(m_ok));
        chk({tag, ".ovc"}, 32'(bus.overrun_cnt), 32'(m_ovc));
    endtask

    task automatic tick(input logic d, input logic ben,
                        input logic rdy, input logic clr);
        @(negedge clk);
        d_drv   = d;
        ben_drv = ben;
        rdy_drv = rdy;
        clr_drv = clr;
        @(posedge clk);
    endtask

    task automatic flush();
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Junk on the line between strobes must be ignored.
    task automatic strobe(input logic b, input int gap);
        for (int j = 1; j < gap; j++) begin
            tick(1'($urandom), 1'b0, 1'b0, 1'b0);
        end
        tick(b, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic send_nf(input bit [7:0] data, input bit stopb,
                           input bit rdy, input bit clr, input int gap);
        bit drained;
        strobe(1'b1, gap);
        for (int i = 0; i < DW; i++) begin
            strobe(data[i], gap);
        end
        for (int j = 1; j < gap; j++) begin
            tick(1'($urandom), 1'b0, 1'b0, 1'b0);
        end
        tick(stopb, 1'b1, rdy, clr);
        drained = m_valid && rdy;
        if (clr) begin
            m_fe = 1'b0;
            m_ov = 1'b0;
        end
        if (!stopb) begin
            if (!m_valid || rdy) begin
                m_data  = data;
                m_valid = 1'b1;
                m_ok    = (m_ok < CMAX) ? m_ok + 1 : CMAX;
            end else begin
                m_ov  = 1'b1;
                m_ovc = (m_ovc < CMAX) ? m_ovc + 1 : CMAX;
            end
        end else begin
            m_fe = 1'b1;
            if (drained) m_valid = 1'b0;
        end
    endtask

    task automatic send(input bit [7:0] data, input bit stopb,
                        input bit rdy, input bit clr, input int gap);
        send_nf(data, stopb, rdy, clr, gap);
        flush();
    endtask

    task automatic drain();
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        m_valid = 1'b0;
    endtask

    task automatic clear();
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        m_fe = 1'b0;
        m_ov = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        d_drv   = 1'b0;
        ben_drv = 1'b0;
        rdy_drv = 1'b0;
        clr_drv = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        m_valid = 1'b0;
        m_data  = '0;
        m_fe    = 1'b0;
        m_ov    = 1'b0;
        m_ok    = 0;
        m_ovc   = 0;
    endtask

    initial begin
        rst     = 1'b1;
        d_drv   = 1'b0;
        ben_drv = 1'b0;
        rdy_drv = 1'b0;
        clr_drv = 1'b0;
        do_reset();
        check_all("reset");

        // Good frame and one-cycle latency after the stop sample.
        send_nf(8'hA5, 1'b0, 1'b0, 1'b0, 1);
        #1;
        chk("a5.pre_valid", 32'(bus.out_valid), 32'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check_all("a5.load");
        drain();
        check_all("a5.drain");

        // Framing error, clear, then a clean frame.
        send(8'h3C, 1'b1, 1'b0, 1'b0, 1);
        check_all("ferr");
        clear();
        check_all("ferr.clr");
        send(8'h3C, 1'b0, 1'b0, 1'b0, 1);
        check_all("3c.good");
        drain();

        // Overrun, then drain and load on the same edge.
        send(8'h11, 1'b0, 1'b0, 1'b0, 1);
        send(8'h22, 1'b0, 1'b0, 1'b0, 1);
        check_all("ovr");
        clear();
        send(8'h22, 1'b0, 1'b1, 1'b0, 1);
        check_all("ovr.simul");
        drain();

        // Sparse strobe with junk between samples.
        send(8'h5A, 1'b0, 1'b0, 1'b0, 3);
        check_all("sparse");
        drain();

        // Reset after four data bits.
        strobe(1'b1, 1);
        for (int i = 0; i < 4; i++) strobe(1'b1, 1);
        do_reset();
        check_all("midrst");
        send(8'hC3, 1'b0, 1'b0, 1'b0, 1);
        check_all("c3");
        drain();

        // Counter saturation.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send(8'(k + 1), 1'b0, 1'b0, 1'b0, 1);
            drain();
        end
        check_all("sat.ok");
        send(8'h77, 1'b0, 1'b0, 1'b0, 1);
        for (int k = 0; k < 5; k++) begin
            send(8'(k + 8'h80), 1'b0, 1'b0, 1'b0, 1);
        end
        check_all("sat.ovc");
        drain();

        // Random frames, flags cleared alongside stop samples.
        do_reset();
        for (int k = 0; k < 40; k++) begin
            send(8'($urandom), ($urandom % 5) == 0, 1'($urandom),
                 ($urandom % 4) == 0, $urandom_range(1, 3));
            check_all("rand");
            if (($urandom % 3) == 0) begin
                drain();
                check_all("rand.drain");
            end
            if (($urandom % 5) == 0) begin
                clear();
                check_all("rand.clr");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_frame_deser.md
Name: serial_frame_deser

Overview:
Downstream consumer of the single-bit registered stream produced by the d_ff stage: samples its q output on a bit strobe and frames it. Frame format is an idle-low line, a start bit of 1, DATA_W data bits LSB first, and a stop bit of 0. Presents assembled words on a valid/ready port through a one-entry holding register. Keeps sticky error flags and saturating statistics counters for bench and debug visibility.

Parameters:
DATA_W, 8, data bits per frame (>=2)
CNT_W, 8, width of the good-frame and overrun statistics counters

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous, active-high reset
din  input  1  serial line; connects to d_ff q
bit_en  input  1  sample strobe; din is sampled only in cycles with bit_en=1
out_data  output  DATA_W  assembled word
out_valid  output  1  out_data holds an undelivered word
out_ready  input  1  consumer accepts when out_valid && out_ready
frame_err  output  1  sticky; a stop bit was sampled as 1
overrun  output  1  sticky; a good frame was dropped because the buffer was occupied
clr_err  input  1  clears frame_err and overrun
frames_ok  output  CNT_W  saturating count of words loaded into out_data
overrun_cnt  output  CNT_W  saturating count of dropped good frames

Behaviour:
- Reset (rst=1 at posedge) forces: state IDLE, bit counter 0, shift register 0, out_data 0, out_valid 0, frame_err 0, overrun 0, frames_ok 0, overrun_cnt 0. Reset has priority over every other input. Reset mid-frame discards the partial frame.
- The FSM advances only in cycles with bit_en=1. With bit_en=0, state, counter and shift register hold.
- IDLE: bit_en && din=1 -> DATA, bit counter=0. din=0 stays in IDLE.
- DATA: each bit_en writes din into shreg[cnt] and increments cnt. When cnt==DATA_W-1 is written -> STOP.
- STOP, bit_en && din=0 (good frame):
  - If the buffer is free, i.e. !out_valid, or out_valid && out_ready in the same cycle: load out_data=shreg, out_valid=1, frames_ok+1.
  - Otherwise: keep the old out_data, set overrun=1, overrun_cnt+1.
  - Next state is IDLE in both cases.
- STOP, bit_en && din=1: set frame_err=1, discard the word, go to IDLE. This stop bit is not reinterpreted as a start bit.
- Latency: out_valid rises on the clock edge that samples the stop bit. It is visible the cycle after the stop-bit bit_en cycle.
- Handshake:
  - out_data is stable while out_valid=1.
  - out_valid falls on the edge where out_valid && out_ready, unless a new word loads on the same edge; in that case out_valid stays 1 with the new data.
  - out_ready while !out_valid has no effect.
- clr_err clears both sticky flags. If a set event and clr_err occur in the same cycle, the set wins.
- Counters saturate at 2^CNT_W-1 and never wrap. clr_err does not clear the counters.
- State encoding: IDLE=0, DATA=1, STOP=2. Encoding 3 is unreachable and must return to IDLE.

Decomposition:
- Shared include/package: state localparams (ST_IDLE, ST_DATA, ST_STOP), START_LVL=1, STOP_LVL=0, IDLE_LVL=0.
- One sub-module, sat_counter (parameter W; ports clk, rst, inc, count), instantiated twice for frames_ok and overrun_cnt.
- The bench instantiates d_ff feeding din. bit_en is tied to the clock-enable cadence of d_ff's d updates.

Test Plan:
- Good frame (bit_en every cycle): din = 1, then 1,0,1,0,0,1,0,1, then stop 0 -> out_data=0xA5, out_valid=1 one cycle after the stop sample. After out_ready=1 for one cycle: out_valid=0, frames_ok=1.
- Framing error: frame 0x3C with stop bit 1 -> frame_err=1, out_valid stays 0, frames_ok unchanged. clr_err pulse -> frame_err=0. Next frame 0x3C with stop 0 -> out_data=0x3C.
- Overrun and simultaneous drain:
  - Frames 0x11 then 0x22 with out_ready=0 -> out_data=0x11, overrun=1, overrun_cnt=1.
  - Repeat with out_ready=1 on the stop-bit cycle of 0x22 -> out_data=0x22, out_valid held 1, no overrun.
- Sparse strobe: bit_en=1 on every 3rd cycle only, with din toggling between strobes -> only strobed samples are captured. Frame 0x5A is received intact.
- Reset mid-frame: rst=1 after 4 data bits -> all outputs 0, state IDLE. A following full frame 0xC3 is received correctly.
- Saturation (CNT_W=2): 5 good frames drained each time -> frames_ok=3 and stays at 3. 5 overruns -> overrun_cnt=3.
